fetch_axi_master: RTL
=====================

// Module: fetch_axi_master
// PURPOSE
// - AXI4 read-channel initiator for instruction fetch; the requesting end of the InstrMem AR/R interface.
// - Issues INCR bursts of 64-bit beats from a fetch PC and splits each beat into two 32-bit instructions.
// - Buffers instructions in a FIFO and presents them one per cycle to decode with valid/ready.
// - Supports pipeline redirect/flush, discarding in-flight beats.
// PARAMETERS
// - RESET_PC   32'h0000_0000  fetch PC after reset; must be 4-byte aligned
// - BURST_LEN  4              max beats per burst (power of 2, 2..16); line = BURST_LEN*8 bytes
// - FIFO_DEPTH 16             instruction entries (power of 2, >= 2*BURST_LEN)
// PORTS
// - clk            in   1   clock, all state on rising edge
// - rst_n          in   1   asynchronous reset, active low
// - arvalid        out  1   AR request valid
// - araddr         out  32  burst start address, 8-byte aligned
// - arburst        out  2   constant 2'b01 (INCR)
// - arsize         out  3   constant 3'b011 (8 bytes)
// - arlen          out  8   beats-1
// - arready        in   1   AR accept
// - rvalid         in   1   R beat valid
// - rdata          in   64  beat; [31:0] = lower address word
// - rlast          in   1   final beat of burst
// - rresp          in   2   response; nonzero = error
// - rready         out  1   R accept
// - redirect_valid in   1   flush and restart fetch
// - redirect_pc    in   32  new fetch PC, 4-byte aligned
// - instr_valid    out  1   FIFO head valid
// - instr_data     out  32  instruction
// - instr_pc       out  32  instruction address
// - instr_err      out  1   instruction came from an error beat
// - instr_ready    in   1   decode accepts head
// BEHAVIOUR
// - Reset: arvalid=0, rready=0, araddr={RESET_PC[31:3],3'b0}, arlen=0, instr_valid=0, FIFO empty, state IDLE, err_stall=0.
// - FSM IDLE->ADDR->DATA->IDLE; DRAIN for flushed bursts. One outstanding burst maximum.
// - IDLE: if !err_stall and FIFO free >= 2*(arlen_next+1): drive araddr={pc[31:3],3'b0}, arlen_next=BURST_LEN-1-pc[log2(BURST_LEN)+2:3]
//   (burst ends at line boundary, never crosses 4KB), arvalid=1 next cycle -> ADDR.
// - ADDR: hold arvalid/araddr/arlen stable until arready; on handshake ->DATA, pc advances to next line start.
// - DATA: rready=1 (space reserved by credit check). Each rvalid beat enqueues two words with pc, pc+4;
//   first beat after redirect with redirect_pc[2]=1 enqueues only upper word. rlast -> IDLE.
// - rresp!=0: beat enqueued with instr_err=1; set err_stall; no new AR until redirect.
// - Redirect (any state): FIFO flushed same cycle, pc<=redirect_pc, err_stall<=0, skip-flag set from redirect_pc[2].
//   ADDR: arvalid stays high until arready (no AXI withdrawal), then ->DRAIN. DATA: ->DRAIN.
//   DRAIN: rready=1, beats discarded, rlast -> IDLE. Redirect in DRAIN only updates pc.
// - Redirect same cycle as rvalid beat: beat discarded. Redirect beats instr_ready: flush wins, no dequeue counted.
// - Dequeue: instr_valid=!empty; head popped when instr_valid&instr_ready; FIFO first-word-fall-through, latency
//   enqueue->instr_valid 1 cycle. Simultaneous 2-in/1-out allowed; pointers wrap modulo FIFO_DEPTH.
// - Min latency: redirect -> arvalid 1 cycle; rvalid beat -> instr_valid next cycle.
// STRUCTURE
// - fetch_pkg: AXI_BURST_INCR, AXI_SIZE_8B, AXI_RESP_OKAY constants; fsm state enum {IDLE,ADDR,DATA,DRAIN};
//   fifo entry type {err,pc[31:0],data[31:0]}.
// - Sub-module fetch_fifo: 2-write/1-read FWFT FIFO with count, flush, free-slot output for credit check.
// - Top of this block: FSM, pc/skip/err_stall regs, AR drive, beat split.
// TESTING
// - Reset, RESET_PC=0, responder always ready -> AR araddr=0 arlen=3; 8 instrs pc 0..0x1C in order, then araddr=0x20.
// - redirect_pc=0x1C idle -> araddr=0x18 arlen=0; only word at 0x1C enqueued; next AR araddr=0x20 arlen=3.
// - instr_ready=0, FIFO_DEPTH=16 -> exactly two bursts fetched, third AR withheld until >=8 free.
// - Redirect during DATA beat 2 of 4 -> FIFO empty next cycle, beats 3-4 discarded, new AR only after rlast.
// - Redirect while arvalid=1 & arready=0 for 5 cycles -> arvalid/araddr stable, then DRAIN full burst.
// - rresp=2'b10 on beat 1 -> two instrs with instr_err=1, no further AR until redirect_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared AXI constants, FSM state and FIFO entry type for the instruction fetch initiator.
package fetch_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} fetch_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-write / one-read first-word-fall-through instruction FIFO with flush and free-slot count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [1:0]  wr_n_i,
  input  fifo_entry_t wr_a_i,
  input  fifo_entry_t wr_b_i,
  input  logic        rd_i,
  output fifo_entry_t head_o,
  output logic        empty_o,
  output logic [AW:0] free_o
);
  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          pop;

  assign empty_o = (cnt_q == '0);
  assign free_o  = (AW+1)'(DEPTH) - cnt_q;
  assign head_o  = mem_q[rptr_q];
  assign pop     = rd_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(wr_n_i);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q  <= cnt_q + (AW+1)'(wr_n_i) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i && wr_n_i != 2'd0) mem_q[wptr_q] <= wr_a_i;
    if (!flush_i && wr_n_i == 2'd2) mem_q[wptr_q + AW'(1)] <= wr_b_i;
  end
endmodule

// File: rtl/fetch_axi_master.sv
// AXI4 read initiator for instruction fetch: line-bounded INCR bursts, beat split into two
// instructions, FWFT buffering toward decode, redirect flush with drain of in-flight bursts.
module fetch_axi_master
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          BURST_LEN  = 4,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [1:0]  arburst,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [63:0] rdata,
  input  logic        rlast,
  input  logic [1:0]  rresp,
  output logic        rready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_err,
  input  logic        instr_ready
);
  localparam int          LB     = $clog2(BURST_LEN);
  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [31:0] LINE_B = 32'(BURST_LEN * 8);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, baddr_q, baddr_d, araddr_q, araddr_d;
  logic [7:0]   arlen_q, arlen_d;
  logic         skip_q, skip_d, stall_q, stall_d, drop_q, drop_d;

  logic [31:0]  eff_pc;
  logic [7:0]   arlen_nxt;
  logic [AW:0]  free, need, eff_free;
  logic         launch, beat_ok, empty;
  logic [1:0]   wr_n;
  fifo_entry_t  wr_a, wr_b, lo_e, hi_e, head;

  // A redirect in IDLE launches straight from redirect_pc against the just-flushed FIFO.
  assign eff_pc    = redirect_valid ? redirect_pc : pc_q;
  assign arlen_nxt = 8'(BURST_LEN - 1) - 8'(eff_pc[LB+2:3]);
  assign need      = (AW+1)'(2 * (int'(arlen_nxt) + 1));
  assign eff_free  = redirect_valid ? (AW+1)'(FIFO_DEPTH) : free;
  assign launch    = (state_q == IDLE) && (redirect_valid || !stall_q) && (eff_free >= need);
  assign beat_ok   = (state_q == DATA) && rvalid && !redirect_valid;

  assign lo_e = '{err: rresp != AXI_RESP_OKAY, pc: baddr_q, data: rdata[31:0]};
  assign hi_e = '{err: rresp != AXI_RESP_OKAY, pc: baddr_q + 32'd4, data: rdata[63:32]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = ADDR;
      ADDR:    if (arready) state_d = (drop_q || redirect_valid) ? DRAIN : DATA;
      DATA:    if (rvalid && rlast) state_d = IDLE;
               else if (redirect_valid) state_d = DRAIN;
      DRAIN:   if (rvalid && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arvalid = (state_q == ADDR);
    rready  = (state_q == DATA) || (state_q == DRAIN);
    wr_n    = 2'd0;
    wr_a    = lo_e;
    wr_b    = hi_e;
    if (beat_ok) begin
      wr_n = skip_q ? 2'd1 : 2'd2;
      if (skip_q) wr_a = hi_e;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    baddr_d  = baddr_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    skip_d   = skip_q;
    stall_d  = stall_q;
    drop_d   = drop_q;
    if (launch) begin
      araddr_d = eff_pc & ~32'h7;
      arlen_d  = arlen_nxt;
      drop_d   = 1'b0;
    end
    if (state_q == ADDR && arready) begin
      baddr_d = araddr_q;
      drop_d  = 1'b0;
      if (!drop_q) pc_d = (pc_q & ~(LINE_B - 32'd1)) + LINE_B;
    end
    if (beat_ok) begin
      baddr_d = baddr_q + 32'd8;
      skip_d  = 1'b0;
      if (rresp != AXI_RESP_OKAY) stall_d = 1'b1;
    end
    // The AR already on the bus cannot be withdrawn; remember to drain its data instead.
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      skip_d  = redirect_pc[2];
      stall_d = 1'b0;
      if (state_q == ADDR && !arready) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      baddr_q  <= '0;
      araddr_q <= RESET_PC & ~32'h7;
      arlen_q  <= '0;
      skip_q   <= 1'b0;
      stall_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      baddr_q  <= baddr_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      skip_q   <= skip_d;
      stall_q  <= stall_d;
      drop_q   <= drop_d;
    end
  end

  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arburst = AXI_BURST_INCR;
  assign arsize  = AXI_SIZE_8B;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .wr_n_i  (wr_n),
    .wr_a_i  (wr_a),
    .wr_b_i  (wr_b),
    .rd_i    (instr_valid && instr_ready),
    .head_o  (head),
    .empty_o (empty),
    .free_o  (free)
  );

  assign instr_valid = !empty;
  assign instr_data  = head.data;
  assign instr_pc    = head.pc;
  assign instr_err   = head.err;
endmodule
